// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared constants for the bit-serial adder.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : FSM state register type
//   IDLE/RUN/DONE : FSM state encodings
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Purely combinational 1-bit full-adder cell.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Adds A+B+Cin one bit per clock, LSB first, through a single full_adder
// cell and a carry flip-flop.  Result appears WIDTH edges after start is
// accepted, followed by a one-cycle done pulse.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request a new addition (accepted in IDLE only)
//   A, B  : operands, captured on acceptance
//   Cin   : carry in, captured on acceptance
//   S     : registered sum, held until next completion or reset
//   Cout  : registered carry out
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse while S/Cout carry a fresh result
// ---------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy,
   output logic             done
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   state_t            state;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   // Only WIDTH-1 partial sum bits need storing: the final bit comes
   // straight from the cell on the completing edge.
   logic [WIDTH-2:0]  sum_sr;
   logic [WIDTH-2:0]  sum_shift;
   logic              carry;
   logic [CNT_W-1:0]  cnt;
   logic              fa_s;
   logic              fa_c;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB; a 1-bit register has nothing to shift.
   generate
      if (WIDTH > 2) begin : g_wide
         assign sum_shift = {fa_s, sum_sr[WIDTH-2:1]};
      end else begin : g_narrow
         assign sum_shift = fa_s;
      end
   endgenerate

   // NOTE: every register here is assigned with <= so all updates see the
   // pre-edge values (the cell reads a_sr/carry from before the shift).
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         Cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  a_sr   <= A;
                  b_sr   <= B;
                  carry  <= Cin;
                  cnt    <= '0;
                  sum_sr <= '0;
               end
            end
            RUN: begin
               sum_sr <= sum_shift;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= fa_c;
               if (cnt == LAST_BIT) begin
                  // Counter holds at its last value instead of wrapping.
                  state <= DONE;
                  S     <= {fa_s, sum_sr};
                  Cout  <= fa_c;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
